// File: rtl/interrupt_acknowledge_sequencer.sv
// CPU-side INTA sequencer for the XT core: samples INTR at instruction boundaries,
// runs the two-pulse INTA# bus cycle under LOCK#, and hands the vector to the core.
module interrupt_acknowledge_sequencer #(
  parameter int PULSE_WIDTH    = 4,
  parameter int GAP_WIDTH      = 3,
  parameter int RECOVERY_WIDTH = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt,
  input  logic       interrupt_enable,
  input  logic       instruction_boundary,
  input  logic [7:0] data_bus_in,
  output logic       interrupt_acknowledge_n,
  output logic       bus_lock_n,
  output logic       busy,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready
);

  // Handshake: the vector transfers on any cycle where vector_valid and
  // vector_ready are both 1; vector_valid then drops at the next edge.

  localparam logic [3:0] PULSE_LAST    = 4'(PULSE_WIDTH - 1);
  localparam logic [3:0] GAP_LAST      = 4'(GAP_WIDTH - 1);
  localparam logic [3:0] RECOVERY_LAST = 4'(RECOVERY_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INTA1   = 3'd1,
    GAP     = 3'd2,
    INTA2   = 3'd3,
    DONE    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] counter;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (interrupt && interrupt_enable && instruction_boundary) state_nxt = INTA1;
      INTA1:   if (counter == PULSE_LAST)    state_nxt = GAP;
      GAP:     if (counter == GAP_LAST)      state_nxt = INTA2;
      INTA2:   if (counter == PULSE_LAST)    state_nxt = DONE;
      DONE:    if (vector_valid && vector_ready) state_nxt = RECOVER;
      RECOVER: if (counter == RECOVERY_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      counter                 <= 4'd0;
      interrupt_acknowledge_n <= 1'b1;
      bus_lock_n              <= 1'b1;
      busy                    <= 1'b0;
      vector                  <= 8'h00;
      vector_valid            <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        counter <= 4'd0;
      end else if (state == INTA1 || state == GAP || state == INTA2 || state == RECOVER) begin
        counter <= counter + 4'd1;
      end
      interrupt_acknowledge_n <= !(state_nxt == INTA1 || state_nxt == INTA2);
      bus_lock_n              <= !(state_nxt == INTA1 || state_nxt == GAP || state_nxt == INTA2);
      busy                    <= (state_nxt != IDLE);
      if (state == INTA2 && state_nxt == DONE) begin
        vector       <= data_bus_in;
        vector_valid <= 1'b1;
      end else if (state == DONE && state_nxt == RECOVER) begin
        vector_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Bench for interrupt_acknowledge_sequencer: a directed vector table, hand-written
// corner sequences and random stimulus checked against a timeline model.
module tb_interrupt_acknowledge_sequencer;

  localparam int P = 4;
  localparam int G = 3;
  localparam int R = 2;
  localparam int LAST_INTA = 2 * P + G;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       interrupt = 1'b0;
  logic       interrupt_enable = 1'b0;
  logic       instruction_boundary = 1'b0;
  logic [7:0] data_bus_in = 8'h00;
  logic       vector_ready = 1'b0;
  logic       interrupt_acknowledge_n;
  logic       bus_lock_n;
  logic       busy;
  logic [7:0] vector;
  logic       vector_valid;

  always #5 clock = ~clock;

  interrupt_acknowledge_sequencer #(
    .PULSE_WIDTH(P), .GAP_WIDTH(G), .RECOVERY_WIDTH(R)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .interrupt(interrupt),
    .interrupt_enable(interrupt_enable),
    .instruction_boundary(instruction_boundary),
    .data_bus_in(data_bus_in),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .bus_lock_n(bus_lock_n),
    .busy(busy),
    .vector(vector),
    .vector_valid(vector_valid),
    .vector_ready(vector_ready)
  );

  typedef struct {
    logic       irq, en, bnd;
    logic [7:0] d;
    logic       rdy;
    logic       e_inta, e_lock, e_busy, e_valid;
    logic [7:0] e_vec;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // timeline model: cycle index of the accepted request, cycle from which IDLE holds
  int         req_cyc = -1;
  int         idle_from = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_vec = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    req_cyc = -1;
    idle_from = cyc;
    m_valid = 1'b0;
    m_vec = 8'h00;
    exp_q.delete();
  endtask

  // compare this cycle's outputs with the model, then let the model consume the inputs
  task automatic check_model();
    logic e_inta, e_lock, e_busy;
    int d;
    logic [7:0] sb;
    d = 0;
    e_inta = 1'b1; e_lock = 1'b1; e_busy = 1'b0;
    if (req_cyc >= 0) begin
      d = cyc - req_cyc;
      e_busy = 1'b1;
      e_lock = !(d >= 1 && d <= LAST_INTA);
      e_inta = !((d >= 1 && d <= P) || (d >= P + G + 1 && d <= LAST_INTA));
    end else if (cyc < idle_from) begin
      e_busy = 1'b1;
    end
    chk("model_inta_n", interrupt_acknowledge_n, e_inta);
    chk("model_lock_n", bus_lock_n, e_lock);
    chk("model_busy", busy, e_busy);
    chk("model_valid", vector_valid, m_valid);
    chk("model_vector", vector, m_vec);
    if (vector_valid === 1'b1 && vector_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_vector at cycle %0d: got %02h with no vector expected", cyc, vector);
      end else begin
        sb = exp_q.pop_front();
        vectors--;
        chk("sb_vector", vector, sb);
      end
    end
    if (req_cyc >= 0) begin
      if (d == LAST_INTA) begin
        m_vec = data_bus_in;
        m_valid = 1'b1;
        exp_q.push_back(data_bus_in);
      end else if (d > LAST_INTA && vector_ready) begin
        m_valid = 1'b0;
        req_cyc = -1;
        idle_from = cyc + R + 1;
      end
    end else if (cyc >= idle_from && interrupt && interrupt_enable && instruction_boundary) begin
      req_cyc = cyc;
    end
  endtask

  // driver: inputs applied just after the edge, outputs checked on the falling edge
  task automatic apply(input vec_t v, input bit use_tbl);
    interrupt = v.irq;
    interrupt_enable = v.en;
    instruction_boundary = v.bnd;
    data_bus_in = v.d;
    vector_ready = v.rdy;
    @(negedge clock);
    if (use_tbl) begin
      chk("tbl_inta_n", interrupt_acknowledge_n, v.e_inta);
      chk("tbl_lock_n", bus_lock_n, v.e_lock);
      chk("tbl_busy", busy, v.e_busy);
      chk("tbl_valid", vector_valid, v.e_valid);
      chk("tbl_vector", vector, v.e_vec);
    end
    check_model();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input logic irq, input logic en, input logic bnd,
                     input logic [7:0] d, input logic rdy);
    vec_t v;
    v = '{irq, en, bnd, d, rdy, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < n; i++) apply(v, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inta_n"}, interrupt_acknowledge_n, 1'b1);
    chk({tag, "_lock_n"}, bus_lock_n, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_valid"}, vector_valid, 1'b0);
    chk({tag, "_vector"}, vector, 8'h00);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc++;
    model_reset();
  endtask

  vec_t tbl[16];

  initial begin
    // first sequence: request at cycle 0 only, vector 0D, ready at cycle 14
    for (int i = 0; i < 16; i++) begin
      tbl[i].irq     = (i == 0);
      tbl[i].en      = (i == 0);
      tbl[i].bnd     = (i == 0);
      tbl[i].d       = 8'h0D;
      tbl[i].rdy     = (i == 14);
      tbl[i].e_inta  = !((i >= 1 && i <= 4) || (i >= 8 && i <= 11));
      tbl[i].e_lock  = !(i >= 1 && i <= 11);
      tbl[i].e_busy  = (i >= 1);
      tbl[i].e_valid = (i >= 12 && i <= 14);
      tbl[i].e_vec   = (i >= 12) ? 8'h0D : 8'h00;
    end

    repeat (2) @(posedge clock);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    cyc = 0;
    model_reset();

    for (int i = 0; i < 16; i++) apply(tbl[i], 1'b1);
    run(2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // request masked by IF for 20 cycles, then enabled
    run(20, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    chk("masked_busy", busy, 1'b0);
    run(1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0);
    chk("enable_inta_low", interrupt_acknowledge_n, 1'b0);
    run(30, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1);

    // request held off until the instruction boundary
    run(5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("no_boundary_busy", busy, 1'b0);
    run(1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    run(11, 1'b0, 1'b0, 1'b0, 8'h6C, 1'b0);
    chk("boundary_latency_valid", vector_valid, 1'b1);
    chk("boundary_latency_vector", vector, 8'h6C);
    run(6, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // INTR drops during GAP: spurious vector still captured
    run(1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    run(4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    run(7, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
    chk("spurious_valid", vector_valid, 1'b1);
    chk("spurious_vector", vector, 8'hFF);
    run(6, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // stall in DONE with INTR still high, then release and re-request
    run(1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    run(11, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    run(10, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    chk("stall_valid", vector_valid, 1'b1);
    chk("stall_vector", vector, 8'h5A);
    chk("stall_inta_n", interrupt_acknowledge_n, 1'b1);
    run(1, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
    chk("handoff_valid_clear", vector_valid, 1'b0);
    chk("handoff_vector_kept", vector, 8'h5A);
    run(3, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    chk("rerequest_inta_low", interrupt_acknowledge_n, 1'b0);
    run(25, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);

    // reset in the middle of INTA2
    run(1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
    run(9, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0);
    async_reset();
    run(6, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1);
    chk("post_reset_valid", vector_valid, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      run(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 2) == 0));
    end
    run(30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_acknowledge_sequencer.md
Name: interrupt_acknowledge_sequencer

Overview:
- CPU-side counterpart of the 8259 interrupt controller in the XT core.
- Samples INTR at instruction boundaries when interrupts are enabled, then runs the 8088 two-pulse INTA bus sequence with LOCK held.
- Captures the vector byte driven by the 8259 during the second pulse and hands it to the CPU core over a valid/ready handshake.

Parameters:
- PULSE_WIDTH, 4, clock cycles each INTA# pulse stays low; legal range 1..15.
- GAP_WIDTH, 3, clock cycles INTA# stays high between the two pulses; legal range 1..15.
- RECOVERY_WIDTH, 2, idle cycles after vector handoff before a new request is accepted; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- interrupt  input  1  INTR from the 8259; level, active-high.
- interrupt_enable  input  1  CPU IF flag; 1 = maskable interrupts accepted.
- instruction_boundary  input  1  1 = CPU core is at an instruction boundary this cycle.
- data_bus_in  input  8  system data bus; the 8259 drives the vector here during the second INTA.
- interrupt_acknowledge_n  output  1  INTA# to the 8259; active-low, registered.
- bus_lock_n  output  1  LOCK#; active-low, registered.
- busy  output  1  1 whenever the state is not IDLE.
- vector  output  8  captured interrupt vector.
- vector_valid  output  1  1 = vector holds an unconsumed value.
- vector_ready  input  1  CPU core accepts the vector when vector_valid and vector_ready are both 1.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, counter=0.
  - interrupt_acknowledge_n=1, bus_lock_n=1, busy=0, vector=8'h00, vector_valid=0.
  - Takes effect immediately, including mid-sequence. No partial pulse resumes after reset is released.
- States: IDLE, INTA1, GAP, INTA2, DONE, RECOVER. A 4-bit counter clears on every state change.
- IDLE:
  - If interrupt & interrupt_enable & instruction_boundary are all 1 in a cycle, go to INTA1 at the next edge.
  - Otherwise stay in IDLE.
- INTA1:
  - interrupt_acknowledge_n=0, bus_lock_n=0.
  - Stay for exactly PULSE_WIDTH cycles, then go to GAP.
- GAP:
  - interrupt_acknowledge_n=1, bus_lock_n=0.
  - Stay for exactly GAP_WIDTH cycles, then go to INTA2.
- INTA2:
  - interrupt_acknowledge_n=0, bus_lock_n=0.
  - Stay for exactly PULSE_WIDTH cycles.
  - On the edge that leaves INTA2, register data_bus_in into vector and set vector_valid=1. Next state is DONE.
- DONE:
  - interrupt_acknowledge_n=1, bus_lock_n=1.
  - vector and vector_valid hold while vector_ready=0.
  - On a cycle with vector_valid=1 and vector_ready=1, clear vector_valid at the next edge and go to RECOVER. vector keeps its value.
- RECOVER:
  - All strobes inactive.
  - Stay for RECOVERY_WIDTH cycles, then go to IDLE.
  - Requests seen during RECOVER are ignored. A still-asserted INTR is re-evaluated in IDLE.
- Output timing:
  - All outputs are registered, derived from the next state.
  - INTA# first goes low the cycle after the request is sampled.
  - Fixed latency from the request cycle to vector_valid=1 is 2*PULSE_WIDTH+GAP_WIDTH+1 edges.
- Boundary conditions:
  - interrupt or interrupt_enable dropping after the sequence leaves IDLE does not abort it. The full sequence runs and the bus value is captured (8259 spurious vector case).
  - vector_ready=1 outside DONE is ignored.
  - A request in the same cycle as reset release is not taken; the first sample is at the first edge with reset_n=1.
  - The counter never wraps: parameter values of 0 or above 15 are illegal, and the counter is compared to value-1.

Test Plan:
- Defaults; reset_n=1; interrupt=interrupt_enable=instruction_boundary=1 at cycle 0; data_bus_in=8'h0D during INTA2 -> INTA# low cycles 1-4, high 5-7, low 8-11; LOCK# low cycles 1-11; vector=8'h0D and vector_valid=1 from cycle 12.
- interrupt=1, interrupt_enable=0 for 20 cycles -> INTA# and LOCK# stay 1, busy=0; raise interrupt_enable at cycle 20 with boundary=1 -> INTA# low at cycle 21.
- Request with instruction_boundary=0 for 5 cycles, then 1 -> no activity until the cycle after the boundary; sequence timing is then identical to the first scenario.
- interrupt drops in GAP; data_bus_in=8'hFF -> sequence completes, vector=8'hFF, vector_valid=1.
- vector_ready=0 for 10 cycles in DONE -> vector and vector_valid stable, no new INTA# despite interrupt=1; ready=1 -> valid=0 next edge, 2 RECOVER cycles, then a new sequence starts if the request is still present.
- reset_n pulsed low mid-INTA2 -> INTA#=1, LOCK#=1, vector_valid=0 immediately; after release, state is IDLE and no stale vector is presented.
